// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, WAIT} arb_state_t;
  localparam int PORT_CORE = 0;
  localparam int PORT_AUX = 1;
  localparam int MEM_LAT_MAX = 4;
endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick with a registered priority pointer.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       sel
);
  logic fav;

  assign sel = (&req) ? fav : req[PORT_AUX];

  // after a grant the loser of the next tie is the port that just won
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fav <= 1'b0;
    end else if (grant_en) begin
      fav <= ~sel;
    end
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port data memory between the core and aux ports,
// one access in flight at a time.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LAT = (MEM_LAT < 1) ? 1 :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int CW = $clog2(LAT + 1);

  arb_state_t        state, nstate;
  logic              sel, grant_en;
  logic              strobe, fin;
  logic              lat_we, lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata_q [2];

  assign grant_en = (state == IDLE) && (p0_req || p1_req);

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({p1_req, p0_req}),
    .grant_en (grant_en),
    .sel      (sel)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (p0_req || p1_req) nstate = STROBE;
      STROBE:  nstate = WAIT;
      WAIT:    if (cnt == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_we     <= 1'b0;
      lat_idx    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cnt        <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state <= nstate;
      if (grant_en) begin
        lat_idx   <= sel;
        lat_we    <= sel ? p1_we : p0_we;
        lat_addr  <= sel ? p1_addr : p0_addr;
        lat_wdata <= sel ? p1_wdata : p0_wdata;
      end
      if (state == STROBE) begin
        cnt <= lat_we ? '0 : CW'(LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fin && !lat_we) begin
        rdata_q[lat_idx] <= mem_rdata;
      end
    end
  end

  assign strobe = (state == STROBE);
  assign fin    = (state == WAIT) && (cnt == '0);

  assign mem_rd    = strobe & ~lat_we;
  assign mem_wr    = strobe & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != IDLE);

  assign p0_gnt  = strobe & ~lat_idx;
  assign p1_gnt  = strobe & lat_idx;
  assign p0_done = fin & ~lat_idx;
  assign p1_done = fin & lat_idx;

  // read data is forwarded in the done cycle, then held by the register
  assign p0_rdata = (p0_done && !lat_we) ? mem_rdata : rdata_q[PORT_CORE];
  assign p1_rdata = (p1_done && !lat_we) ? mem_rdata : rdata_q[PORT_AUX];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [8:0]  p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wr, busy;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        b_p0_req = 0, b_p0_we = 0, b_p1_req = 0, b_p1_we = 0;
  logic [8:0]  b_p0_addr = 0, b_p1_addr = 0;
  logic [31:0] b_p0_wdata = 0, b_p1_wdata = 0;
  logic        b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic        b_mem_rd, b_mem_wr, b_busy;
  logic [8:0]  b_mem_addr;
  logic [31:0] b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'h0BAD_0BAD;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(LAT_A)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MEM_LAT(LAT_B)) dut3 (
    .clk(clk), .reset(reset),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr),
    .p0_wdata(b_p0_wdata), .p0_gnt(b_p0_gnt), .p0_done(b_p0_done),
    .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr),
    .p1_wdata(b_p1_wdata), .p1_gnt(b_p1_gnt), .p1_done(b_p1_done),
    .p1_rdata(b_p1_rdata),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] init_val(input logic [8:0] a);
    return (a == 9'h010) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | {23'h0, a});
  endfunction

  bit [31:0]  dmem [512];
  bit         dval [512];
  bit         rd_q;
  logic [8:0] rd_addr = '0;

  always @(posedge clk) begin
    if (mem_wr) begin
      dmem[mem_addr] <= mem_wdata;
      dval[mem_addr] <= 1'b1;
    end
    rd_q <= mem_rd;
    if (mem_rd) rd_addr <= mem_addr;
  end

  assign mem_rdata = !rd_q ? 32'hBAD0_BAD0 :
                     dval[rd_addr] ? dmem[rd_addr] : init_val(rd_addr);

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({p0_gnt, p0_done, p1_gnt, p1_done, mem_rd, mem_wr, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl got=%b exp=0",
        {p0_gnt, p0_done, p1_gnt, p1_done, mem_rd, mem_wr, busy});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, p0_rdata, p1_rdata} !== 105'b0) begin
      n_err++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0",
        mem_addr, mem_wdata, p0_rdata, p1_rdata);
    end
    n_cmp++;
    if ({b_p0_gnt, b_p1_gnt, b_mem_rd, b_mem_wr, b_busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl_b got=%b exp=0",
        {b_p0_gnt, b_p1_gnt, b_mem_rd, b_mem_wr, b_busy});
    end
    reset = 1'b1;
  endtask

  task automatic test_read();
    p0_req = 1; p0_we = 0; p0_addr = 9'h010;
    @(negedge clk);
    n_cmp++;
    if ({mem_rd, mem_wr, p0_gnt, p1_gnt, p0_done, busy} !== 6'b101001 ||
        mem_addr !== 9'h010) begin
      n_err++;
      $display("FAIL read_strobe got=%b addr=%h exp=101001 addr=010",
        {mem_rd, mem_wr, p0_gnt, p1_gnt, p0_done, busy}, mem_addr);
    end
    p0_req = 0;
    @(negedge clk);
    n_cmp++;
    if (p0_done !== 1'b1 || mem_rd !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_done got done=%b rd=%b rdata=%h exp 1 0 deadbeef",
        p0_done, mem_rd, p0_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (p0_done !== 1'b0 || busy !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL read_hold got done=%b busy=%b rdata=%h exp 0 0 deadbeef",
        p0_done, busy, p0_rdata);
    end
  endtask

  task automatic test_write();
    p1_req = 1; p1_we = 1; p1_addr = 9'h1FF; p1_wdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({mem_wr, mem_rd, p1_gnt, p0_gnt} !== 4'b1010 ||
        mem_addr !== 9'h1FF || mem_wdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL write_strobe got=%b addr=%h wdata=%h exp=1010 1ff 12345678",
        {mem_wr, mem_rd, p1_gnt, p0_gnt}, mem_addr, mem_wdata);
    end
    p1_req = 0; p1_addr = 9'h000; p1_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++;
    if (p1_done !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h1FF) begin
      n_err++;
      $display("FAIL write_done got done=%b wr=%b addr=%h exp 1 0 1ff",
        p1_done, mem_wr, mem_addr);
    end
    @(negedge clk);
    p1_req = 1; p1_we = 0; p1_addr = 9'h1FF;
    @(negedge clk);
    p1_req = 0;
    @(negedge clk);
    n_cmp++;
    if (p1_done !== 1'b1 || p1_rdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL write_readback got done=%b rdata=%h exp 1 12345678",
        p1_done, p1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_alternate();
    int g = 0;
    bit exp_p1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 9'h020;
    p1_req = 1; p1_we = 0; p1_addr = 9'h021;
    for (int c = 0; c < 40 && g < 8; c++) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) begin
        n_cmp++;
        if ({p0_gnt, p1_gnt} !== (exp_p1 ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("FAIL alternate grant %0d got=%b exp_p1=%b",
            g, {p0_gnt, p1_gnt}, exp_p1);
        end
        g++;
        exp_p1 = ~exp_p1;
      end
    end
    p0_req = 0; p1_req = 0;
    n_cmp++;
    if (g != 8) begin
      n_err++;
      $display("FAIL alternate_count got=%0d exp=8", g);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lat3();
    b_p0_req = 1; b_p0_we = 0; b_p0_addr = 9'h005;
    b_mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    n_cmp++;
    if ({b_mem_rd, b_p0_gnt, b_busy, b_p0_done} !== 4'b1110) begin
      n_err++;
      $display("FAIL lat3_strobe got=%b exp=1110",
        {b_mem_rd, b_p0_gnt, b_busy, b_p0_done});
    end
    b_p0_req = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b_busy !== 1'b1 || b_p0_done !== 1'b0 || b_mem_rd !== 1'b0) begin
        n_err++;
        $display("FAIL lat3_wait%0d got busy=%b done=%b rd=%b exp 1 0 0",
          i, b_busy, b_p0_done, b_mem_rd);
      end
    end
    @(negedge clk);
    b_mem_rdata = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (b_p0_done !== 1'b1 || b_busy !== 1'b1 ||
        b_p0_rdata !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL lat3_done got done=%b busy=%b rdata=%h exp 1 1 cafef00d",
        b_p0_done, b_busy, b_p0_rdata);
    end
    @(negedge clk);
    b_mem_rdata = 32'h0BAD_0BAD;
    #1;
    n_cmp++;
    if (b_p0_done !== 1'b0 || b_busy !== 1'b0 ||
        b_p0_rdata !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL lat3_hold got done=%b busy=%b rdata=%h exp 0 0 cafef00d",
        b_p0_done, b_busy, b_p0_rdata);
    end
  endtask

  task automatic test_reset_abort();
    bit seen_done = 1'b0;
    b_p1_req = 1; b_p1_we = 0; b_p1_addr = 9'h007;
    @(negedge clk);
    n_cmp++;
    if (b_p1_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL abort_gnt got=%b exp=1", b_p1_gnt);
    end
    b_p1_req = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done, b_mem_rd, b_mem_wr,
         b_busy} !== 7'b0 ||
        {b_mem_addr, b_mem_wdata, b_p0_rdata, b_p1_rdata} !== 105'b0) begin
      n_err++;
      $display("FAIL abort_outputs got ctl=%b addr=%h rdata0=%h rdata1=%h exp 0",
        {b_p0_gnt, b_p0_done, b_p1_gnt, b_p1_done, b_mem_rd, b_mem_wr, b_busy},
        b_mem_addr, b_p0_rdata, b_p1_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b_p1_done || b_busy) seen_done = 1'b1;
    end
    n_cmp++;
    if (seen_done) begin
      n_err++;
      $display("FAIL abort_no_done got=1 exp=0");
    end
    reset = 1'b1;
    b_p0_req = 1; b_p0_we = 0; b_p0_addr = 9'h001;
    b_p1_req = 1; b_p1_we = 0; b_p1_addr = 9'h002;
    @(negedge clk);
    n_cmp++;
    if ({b_p0_gnt, b_p1_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_first_pick got=%b exp=10", {b_p0_gnt, b_p1_gnt});
    end
    b_p0_req = 0; b_p1_req = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_withdraw();
    bit stray = 1'b0;
    p1_req = 1; p1_we = 0; p1_addr = 9'h003;
    @(negedge clk);
    n_cmp++;
    if (p1_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL withdraw_p1_gnt got=%b exp=1", p1_gnt);
    end
    p1_req = 0;
    p0_req = 1; p0_we = 1; p0_addr = 9'h055; p0_wdata = 32'h5555_AAAA;
    @(negedge clk);
    n_cmp++;
    if (p1_done !== 1'b1 || p1_rdata !== init_val(9'h003)) begin
      n_err++;
      $display("FAIL withdraw_p1_done got done=%b rdata=%h exp 1 %h",
        p1_done, p1_rdata, init_val(9'h003));
    end
    p0_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (p0_gnt || mem_rd || mem_wr) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_err++;
      $display("FAIL withdraw_stray_access got=1 exp=0");
    end
  endtask

  task automatic test_random();
    logic [31:0] rmem [512];
    logic [31:0] rd_m [2];
    logic [8:0]  l_addr;
    logic [31:0] l_wdata, e_data;
    logic [6:0]  exp_ctl, got_ctl;
    int s_at, d_at, free_at;
    bit fav, win, m_we;
    for (int i = 0; i < 512; i++)
      rmem[i] = dval[i] ? dmem[i] : init_val(9'(i));
    p0_req = 0; p1_req = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s_at = -1; d_at = -1; free_at = 0;
    fav = 0; win = 0; m_we = 0;
    l_addr = '0; l_wdata = '0; e_data = '0;
    rd_m[0] = '0; rd_m[1] = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == d_at && !m_we) rd_m[win] = e_data;
      exp_ctl = {c == s_at && !win, c == s_at && win,
                 c == s_at && !m_we, c == s_at && m_we,
                 c == d_at && !win, c == d_at && win,
                 c >= s_at && c <= d_at};
      got_ctl = {p0_gnt, p1_gnt, mem_rd, mem_wr, p0_done, p1_done, busy};
      n_cmp++;
      if (got_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, got_ctl, exp_ctl);
      end
      n_cmp++;
      if (mem_addr !== l_addr || mem_wdata !== l_wdata) begin
        n_err++;
        $display("FAIL rand_mem cyc=%0d got=%h/%h exp=%h/%h",
          c, mem_addr, mem_wdata, l_addr, l_wdata);
      end
      n_cmp++;
      if (p0_rdata !== rd_m[0] || p1_rdata !== rd_m[1]) begin
        n_err++;
        $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h",
          c, p0_rdata, p1_rdata, rd_m[0], rd_m[1]);
      end
      if (p0_req && !(c == s_at && !win)) begin
        if ($urandom_range(0, 7) == 0) p0_req = 0;
      end else begin
        p0_req = ($urandom_range(0, 2) == 0);
        p0_we = $urandom_range(0, 1) == 1;
        p0_addr = 9'($urandom_range(0, 15));
        p0_wdata = $urandom;
      end
      if (p1_req && !(c == s_at && win)) begin
        if ($urandom_range(0, 7) == 0) p1_req = 0;
      end else begin
        p1_req = ($urandom_range(0, 2) == 0);
        p1_we = $urandom_range(0, 1) == 1;
        p1_addr = 9'($urandom_range(0, 15));
        p1_wdata = $urandom;
      end
      if (c >= free_at && (p0_req || p1_req)) begin
        win = (p0_req && p1_req) ? fav : p1_req;
        fav = ~win;
        m_we = win ? p1_we : p0_we;
        l_addr = win ? p1_addr : p0_addr;
        l_wdata = win ? p1_wdata : p0_wdata;
        s_at = c + 1;
        d_at = m_we ? c + 2 : c + 1 + LAT_A;
        free_at = d_at + 1;
        if (m_we) rmem[l_addr] = l_wdata;
        else e_data = rmem[l_addr];
      end
    end
    p0_req = 0; p1_req = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_alternate();
    test_lat3();
    test_reset_abort();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
